hs_buffered_slave: RTL and testbench

Parametrised valid/ready receive endpoint with an internal first-word-fall-through buffer. It replaces the single-register slave: it accepts words from an upstream master while enabled, buffers up to DEPTH of them, and presents them to a downstream consumer on its own valid/ready pair. It sits between a streaming master and a consumer that may stall, and adds occupancy status and a selectable idle-output mode.

---
 rtl/hs_buffered_slave_if.sv | 36 +++
 rtl/hs_buffered_slave.sv | 88 ++++++++
 tb/tb_hs_buffered_slave.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hs_buffered_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : hs_buffered_slave_if
// Description : Upstream/downstream valid-ready bundle plus occupancy status
//               for the buffered receive endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_buffered_slave_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             en;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    // Endpoint view: receives upstream words, presents buffered words downstream.
    modport slave (
        input  en, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, count, full, empty
    );

    // Environment view: drives the upstream word and downstream acceptance.
    modport master (
        output en, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/hs_buffered_slave.sv
`default_nettype none
// ============================================================================
// Module      : hs_buffered_slave
// Description : Valid/ready receive endpoint with a DEPTH-entry first-word-
//               fall-through buffer, occupancy status and selectable idle
//               value on the downstream data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_buffered_slave #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int IDLE_ONES = 1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hs_buffered_slave_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);

    logic             r_en;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Status comes only from the occupancy counter; pointers never compared.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // s_ready depends on registers only, so no combinational path from s_valid or m_ready.
    assign bus.s_ready = r_en && !w_full;
    assign bus.m_valid = !w_empty;
    assign bus.count   = r_count;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;

    assign w_push = bus.s_valid && bus.s_ready;
    assign w_pop  = bus.m_valid && bus.m_ready;

    // Enable register, pointers and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_en <= bus.en;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage; contents are meaningless until written, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.s_data;
    end

    generate
        if (IDLE_ONES != 0) begin : g_idle_ones
            assign bus.m_data = bus.m_valid ? w_head : {WIDTH{1'b1}};
        end else begin : g_hold_last
            logic [WIDTH-1:0] r_last;

            // Remember the most recently popped word to show while idle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        r_last <= '0;
                else if (w_pop) r_last <= w_head;
            end

            assign bus.m_data = bus.m_valid ? w_head : r_last;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_hs_buffered_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_buffered_slave
// Description : Self-checking bench; drives one all-ones-idle instance and one
//               hold-last instance with identical stimulus and compares both
//               against a queue-based model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_buffered_slave;
    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       en      = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       m_ready = 1'b0;

    hs_buffered_slave_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) bo ();
    hs_buffered_slave_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) bh ();

    assign bo.en = en;  assign bo.s_valid = s_valid;  assign bo.s_data = s_data;  assign bo.m_ready = m_ready;
    assign bh.en = en;  assign bh.s_valid = s_valid;  assign bh.s_data = s_data;  assign bh.m_ready = m_ready;

    hs_buffered_slave #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .IDLE_ONES(1)) u_ones (
        .clk (clk), .rst (rst), .bus (bo.slave)
    );
    hs_buffered_slave #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .IDLE_ONES(0)) u_hold (
        .clk (clk), .rst (rst), .bus (bh.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_en   = 1'b0;
    logic [7:0] m_last = 8'h00;
    bit         last_push;
    logic [7:0] dut_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model's view.
    task automatic check_all();
        logic [7:0] head;
        int         sz;
        sz   = mq.size();
        head = (sz > 0) ? mq[0] : 8'h00;
        chk("ones.s_ready", bo.s_ready, m_en && (sz < c_DEPTH));
        chk("ones.m_valid", bo.m_valid, sz > 0);
        chk("ones.m_data",  bo.m_data,  (sz > 0) ? head : 8'hFF);
        chk("ones.count",   bo.count,   sz);
        chk("ones.full",    bo.full,    sz == c_DEPTH);
        chk("ones.empty",   bo.empty,   sz == 0);
        chk("hold.s_ready", bh.s_ready, m_en && (sz < c_DEPTH));
        chk("hold.m_valid", bh.m_valid, sz > 0);
        chk("hold.m_data",  bh.m_data,  (sz > 0) ? head : m_last);
        chk("hold.count",   bh.count,   sz);
        chk("hold.full",    bh.full,    sz == c_DEPTH);
        chk("hold.empty",   bh.empty,   sz == 0);
    endtask

    // One clock: model decides push/pop from pre-edge state, then the edge, then compare.
    task automatic step();
        bit rdy, push, pop;
        rdy  = m_en && (mq.size() < c_DEPTH);
        push = s_valid && rdy;
        pop  = (mq.size() > 0) && m_ready;
        if (bo.m_valid && m_ready) dut_log.push_back(bo.m_data);
        if (pop) begin
            m_last = mq[0];
            void'(mq.pop_front());
        end
        if (push) mq.push_back(s_data);
        m_en = en;
        @(posedge clk);
        #1;
        last_push = push;
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        m_en   = 1'b0;
        m_last = 8'h00;
    endtask

    initial begin : main
        logic [7:0] exp_drain [4];

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst.ones_m_data", bo.m_data, 8'hFF);
        chk("rst.hold_m_data", bh.m_data, 8'h00);
        rst = 1'b0;

        // Enable latency: en and a valid word arrive together
        en = 1'b1; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
        step();
        chk("en_lat.s_ready", bo.s_ready, 1'b1);
        chk("en_lat.m_valid", bo.m_valid, 1'b0);
        step();
        s_valid = 1'b0;
        chk("en_lat.m_data", bo.m_data, 8'hA5);
        chk("en_lat.count",  bo.count,  1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Fill to full, then full with simultaneous pop
        for (int w = 1; w <= 4; w++) begin
            s_valid = 1'b1; s_data = 8'(w);
            step();
        end
        chk("fill.count",   bo.count,   4);
        chk("fill.full",    bo.full,    1'b1);
        chk("fill.s_ready", bo.s_ready, 1'b0);
        s_data = 8'h05; m_ready = 1'b1;
        step();
        chk("fullpop.count",  bo.count,  3);
        chk("fullpop.m_data", bo.m_data, 8'h02);
        m_ready = 1'b0;
        step();
        chk("fullpop.accept05", bo.count, 4);
        s_valid = 1'b0; m_ready = 1'b1;
        exp_drain = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 4; i++) begin
            chk("drain.order", bo.m_data, exp_drain[i]);
            step();
        end
        chk("drain.empty", bo.empty, 1'b1);

        // Streaming with wrap-around
        dut_log.delete();
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_data = 8'h10 + 8'(i);
            step();
            chk("stream.accepted", last_push, 1'b1);
            chk("stream.count_le1", bo.count <= 1, 1'b1);
        end
        s_valid = 1'b0;
        step();
        chk("stream.n_out", dut_log.size(), 20);
        for (int i = 0; i < 20 && i < dut_log.size(); i++)
            chk("stream.order", dut_log[i], 8'h10 + 8'(i));

        // Hold-last idle value
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h3C;
        step();
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        step();
        chk("hold.idle_3c", bh.m_data, 8'h3C);
        chk("hold.idle_valid", bh.m_valid, 1'b0);
        chk("ones.idle_ff", bo.m_data, 8'hFF);

        // en deasserted with two words buffered
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'h61; step();
        s_data = 8'h62; step();
        s_valid = 1'b0; en = 1'b0;
        chk("endis.same_cycle_ready", bo.s_ready, 1'b1);
        step();
        chk("endis.s_ready", bo.s_ready, 1'b0);
        m_ready = 1'b1;
        chk("endis.w1", bo.m_data, 8'h61);
        step();
        chk("endis.w2", bo.m_data, 8'h62);
        step();
        chk("endis.empty", bo.empty, 1'b1);

        // Mid-stream reset with three words buffered
        en = 1'b1; m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'h70 + 8'(i);
            step();
        end
        s_valid = 1'b0;
        chk("rst_mid.pre_count", bo.count, 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_mid.count", bo.count, 0);
        chk("rst_mid.hold_m_data", bh.m_data, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Randomized traffic; the master holds an unaccepted word
        s_valid = 1'b0;
        last_push = 1'b0;
        for (int c = 0; c < 400; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if (!(s_valid && !last_push)) begin
                s_valid = $urandom_range(0, 3) != 0;
                s_data  = 8'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
